// File: rtl/sub_select_seq_pkg.sv
// sub_select_pkg: shared FSM state encoding and default sizes for sub_select_seq
package sub_select_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam int WIDTH_DEF = 8;
  localparam int CHUNK_DEF = 4;
endpackage

// File: rtl/sub_select_seq_if.sv
// sub_select_seq_if: operand/result handshake bundle; OVF exists only with SUB_OVF_EN
interface sub_select_seq_if import sub_select_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] DIFF;
  logic             B_OUT;
`ifdef SUB_OVF_EN
  logic             OVF;
`endif
  modport master (
    output IN_VALID, A, B, B_IN, OUT_READY,
`ifdef SUB_OVF_EN
    input  OVF,
`endif
    input  IN_READY, OUT_VALID, DIFF, B_OUT
  );
  modport slave (
    input  IN_VALID, A, B, B_IN, OUT_READY,
`ifdef SUB_OVF_EN
    output OVF,
`endif
    output IN_READY, OUT_VALID, DIFF, B_OUT
  );
endinterface

// File: rtl/sub_select_seq_chunk_sel_add.sv
// chunk_sel_add: one chunk of a + b_inv evaluated for both carry-ins, result picked by sel_c
module chunk_sel_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_inv,
  input  logic             sel_c,
  output logic [CHUNK-1:0] s0,
  output logic             c0,
  output logic [CHUNK-1:0] s1,
  output logic             c1,
  output logic [CHUNK-1:0] s,
  output logic             c
);
  // both carry assumptions in parallel, then a late select on the registered carry
  always_comb begin
    {c0, s0} = {1'b0, a} + {1'b0, b_inv};
    {c1, s1} = {1'b0, a} + {1'b0, b_inv} + (CHUNK + 1)'(1);
    s = sel_c ? s1 : s0;
    c = sel_c ? c1 : c0;
  end
endmodule

// File: rtl/sub_select_seq.sv
// sub_select_seq: multi-cycle carry-select subtractor, DIFF = A - B - B_IN, CHUNK bits per clock
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module sub_select_seq import sub_select_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic CLK,
  input logic RST_N,
  sub_select_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             c_q, c_d, bout_q, bout_d;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic [CHUNK-1:0] unused_s0, unused_s1;
  logic             unused_c0, unused_c1;
  logic             last;
`ifdef SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign last = idx_q == IW'(N - 1);

  chunk_sel_add #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[idx_q*CHUNK +: CHUNK]),
    .b_inv (~b_q[idx_q*CHUNK +: CHUNK]),
    .sel_c (c_q),
    .s0    (unused_s0),
    .c0    (unused_c0),
    .s1    (unused_s1),
    .c1    (unused_c1),
    .s     (sum),
    .c     (cout)
  );

  // next-state: capture operands in IDLE, resolve one chunk per BUSY cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == S_IDLE && bus.IN_VALID) begin
      a_d     = bus.A;
      b_d     = bus.B;
      c_d     = ~bus.B_IN;
      diff_d  = '0;
      idx_d   = '0;
      state_d = S_BUSY;
    end else if (state_q == S_BUSY) begin
      diff_d[idx_q*CHUNK +: CHUNK] = sum;
      c_d   = cout;
      idx_d = last ? '0 : idx_q + IW'(1);
      if (last) begin
        state_d = S_DONE;
        bout_d  = ~cout;
`ifdef SUB_OVF_EN
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
    end else if (state_q == S_DONE && bus.OUT_READY) begin
      state_d = S_IDLE;
    end
  end

  // state registers, cleared asynchronously so a reset discards any operation in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b1;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.IN_READY  = state_q == S_IDLE;
  assign bus.OUT_VALID = state_q == S_DONE;
  assign bus.DIFF      = diff_q;
  assign bus.B_OUT     = bout_q;
`ifdef SUB_OVF_EN
  assign bus.OVF       = ovf_q;
`endif
endmodule
